crossy_game_ctrl: RTL

Top-level game sequencer for the crossy-road VGA game. It owns the run/stop control of the vertical scroll engine by driving that engine's reset and move-enable inputs. It tracks lives and collision handling, and latches the high score from the engine's score output. It sits between the board buttons/collision detector and the scroll engine, and exports state to the renderer.

---
 rtl/crossy_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 74 +++++++
 rtl/crossy_game_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/crossy_pkg.sv
// -----------------------------------------------------------------------------
// crossy_pkg
// Shared definitions for the crossy-road game sequencer: the game_state
// encodings exported to the renderer, score width/limit, and the default
// frame/debounce timing constants used by crossy_game_ctrl and btn_debounce.
// No ports (package only).
// -----------------------------------------------------------------------------
package crossy_pkg;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_READY   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_HIT     = 3'd3,
        ST_OVER    = 3'd4
    } game_state_t;

    localparam int SCORE_W   = 7;
    localparam int SCORE_MAX = 99;

    localparam int LIVES_DEFAULT           = 3;
    localparam int READY_FRAMES_DEFAULT    = 60;
    localparam int HIT_FRAMES_DEFAULT      = 90;
    localparam int FLASH_FRAMES_DEFAULT    = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

    // Lives never wrap below zero, even if a collision arrives with none left.
    function automatic logic [1:0] dec_sat(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Brings one raw, asynchronous board button into the clk domain through a
// 2-flop synchronizer. When DEBOUNCE_EN is defined, a stability counter follows
// the synchronizer: the output level only changes after the synced input has
// held its new value for DEBOUNCE_CYCLES consecutive cycles. Without the macro
// the output is the synchronized level directly.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high
//   btn    in   raw button
//   level  out  synchronized (and optionally debounced) button level
//
// Build option: DEBOUNCE_EN (adds the DEBOUNCE_CYCLES parameter and counter).
// -----------------------------------------------------------------------------
module btn_debounce
    import crossy_pkg::*;
`ifdef DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);

    logic sync1;
    logic sync2;

    // Two-flop synchronizer; the first flop may go metastable, the second
    // gives it a full cycle to settle before anything downstream looks at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] stable_cnt;
    logic          level_q;

    // Count consecutive cycles in which the synced input disagrees with the
    // current output; any return to agreement restarts the count, so a bounce
    // shorter than DEBOUNCE_CYCLES never reaches the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt <= '0;
            level_q    <= 1'b0;
        end else if (sync2 == level_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_cnt <= '0;
            level_q    <= sync2;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign level = level_q;
`else
    assign level = sync2;
`endif

endmodule

// File: rtl/crossy_game_ctrl.sv
// -----------------------------------------------------------------------------
// crossy_game_ctrl
// Top-level game sequencer. Runs the ATTRACT/READY/PLAY/HIT/OVER flow, drives
// the scroll engine's reset and move-enable, tracks lives, and latches the
// high score from the engine's score output when a game ends.
//
// Ports:
//   clk          in   pixel clock (25 MHz)
//   reset        in   synchronous, active-high
//   start_btn    in   raw start button (asynchronous)
//   move_btn     in   raw move button (asynchronous)
//   collision    in   player overlaps an obstacle this cycle
//   frame_tick   in   one-cycle pulse per frame
//   score_in     in   score from scroll engine, 0..99
//   scroll_rst   out  reset to scroll engine
//   scroll_move  out  move enable to scroll engine
//   game_state   out  current game_state_t encoding
//   lives        out  remaining lives
//   high_score   out  best score since reset
//   new_high     out  last game set a new high score
//   flash        out  player-sprite blank toggle during HIT
//
// Build option: DEBOUNCE_EN puts a debouncer behind each button synchronizer.
// -----------------------------------------------------------------------------
module crossy_game_ctrl
    import crossy_pkg::*;
#(
    parameter int LIVES        = LIVES_DEFAULT,
    parameter int READY_FRAMES = READY_FRAMES_DEFAULT,
    parameter int HIT_FRAMES   = HIT_FRAMES_DEFAULT,
    parameter int FLASH_FRAMES = FLASH_FRAMES_DEFAULT
`ifdef DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               move_btn,
    input  logic               collision,
    input  logic               frame_tick,
    input  logic [SCORE_W-1:0] score_in,
    output logic               scroll_rst,
    output logic               scroll_move,
    output logic [2:0]         game_state,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic               flash
);

    localparam int CNT_MAX = (READY_FRAMES > HIT_FRAMES) ? READY_FRAMES : HIT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FL_W    = $clog2(FLASH_FRAMES + 1);

    logic start_lvl;
    logic move_s;
    logic start_prev;
    logic start_edge;

`ifdef DEBOUNCE_EN
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
        .clk(clk), .reset(reset), .btn(start_btn), .level(start_lvl)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_move_btn (
        .clk(clk), .reset(reset), .btn(move_btn), .level(move_s)
    );
`else
    btn_debounce u_start_btn (
        .clk(clk), .reset(reset), .btn(start_btn), .level(start_lvl)
    );
    btn_debounce u_move_btn (
        .clk(clk), .reset(reset), .btn(move_btn), .level(move_s)
    );
`endif

    // Rising-edge detect on the start level, registered so the FSM sees a
    // clean one-cycle pulse three cycles after the raw press.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_prev <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            start_prev <= start_lvl;
            start_edge <= start_lvl & ~start_prev;
        end
    end

    game_state_t        state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               new_high_q, new_high_d;
    logic               flash_q, flash_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FL_W-1:0]    fcnt_q, fcnt_d;
    logic               rst_q, rst_d;
    logic               move_q, move_d;
    logic               over_first_q, over_first_d;
    logic [SCORE_W-1:0] score_c;

    assign score_c = (score_in > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_in;

    // State register plus every registered output; reset clears everything,
    // including the high score.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ATTRACT;
            lives_q      <= 2'(LIVES);
            high_q       <= '0;
            new_high_q   <= 1'b0;
            flash_q      <= 1'b0;
            cnt_q        <= '0;
            fcnt_q       <= '0;
            rst_q        <= 1'b1;
            move_q       <= 1'b0;
            over_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            high_q       <= high_d;
            new_high_q   <= new_high_d;
            flash_q      <= flash_d;
            cnt_q        <= cnt_d;
            fcnt_q       <= fcnt_d;
            rst_q        <= rst_d;
            move_q       <= move_d;
            over_first_q <= over_first_d;
        end
    end

    // Next-state and next-output logic. A frame_tick arriving on a transition
    // edge is counted by the state being left; the new state starts at zero.
    // The OVER entry flag lets the high-score compare happen exactly once.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        high_d       = high_q;
        new_high_d   = new_high_q;
        flash_d      = flash_q;
        cnt_d        = cnt_q;
        fcnt_d       = fcnt_q;
        rst_d        = rst_q;
        move_d       = move_q;
        over_first_d = 1'b0;

        case (state_q)
            ST_ATTRACT: begin
                rst_d  = 1'b1;
                move_d = 1'b0;
                if (start_edge) begin
                    lives_d    = 2'(LIVES);
                    new_high_d = 1'b0;
                    cnt_d      = '0;
                    rst_d      = 1'b0;
                    state_d    = ST_READY;
                end
            end
            ST_READY: begin
                rst_d  = 1'b0;
                move_d = 1'b0;
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(READY_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                rst_d = 1'b0;
                if (collision) begin
                    lives_d = dec_sat(lives_q);
                    move_d  = 1'b0;
                    cnt_d   = '0;
                    fcnt_d  = '0;
                    flash_d = 1'b1;
                    state_d = ST_HIT;
                end else begin
                    move_d = move_s;
                end
            end
            ST_HIT: begin
                rst_d  = 1'b0;
                move_d = 1'b0;
                if (frame_tick) begin
                    if (fcnt_q == FL_W'(FLASH_FRAMES - 1)) begin
                        fcnt_d  = '0;
                        flash_d = ~flash_q;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                    if (cnt_q == CNT_W'(HIT_FRAMES - 1)) begin
                        flash_d      = 1'b0;
                        cnt_d        = '0;
                        over_first_d = (lives_q == 2'd0);
                        state_d      = (lives_q == 2'd0) ? ST_OVER : ST_READY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                rst_d  = 1'b0;
                move_d = 1'b0;
                if (over_first_q && (score_c > high_q)) begin
                    high_d     = score_c;
                    new_high_d = 1'b1;
                end
                if (start_edge) begin
                    rst_d      = 1'b1;
                    lives_d    = 2'(LIVES);
                    new_high_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_READY;
                end
            end
            default: begin
                rst_d   = 1'b1;
                move_d  = 1'b0;
                flash_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_ATTRACT;
            end
        endcase
    end

    assign game_state  = state_q;
    assign lives       = lives_q;
    assign high_score  = high_q;
    assign new_high    = new_high_q;
    assign flash       = flash_q;
    assign scroll_rst  = rst_q;
    assign scroll_move = move_q;

endmodule
